// File: rtl/i2s_adc_rx.sv
// I2S master-mode ADC receiver: generates bclk/adclrc, deserialises adcdat, hands out stereo pairs.
// Define I2S_RX_LJ_EN for left-justified capture (no one-bit delay, WIDTH up to 32).
module i2s_adc_rx #(
    parameter int WIDTH    = 16,
    parameter int BCLK_DIV = 8
) (
    input  logic             osc_clk,
    input  logic             reset,
    output logic             bclk,
    output logic             adclrc,
    input  logic             adcdat,
    output logic [WIDTH-1:0] left_out,
    output logic [WIDTH-1:0] right_out,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

`ifdef I2S_RX_LJ_EN
    localparam int FIRST_BIT = 0;
`else
    localparam int FIRST_BIT = 1;
`endif

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [5:0]       FIRST_SLOT = 6'(FIRST_BIT);
    localparam logic [5:0]       SLOT_BITS  = 6'(WIDTH);
    localparam logic [5:0]       COMMIT_CNT = 6'(32 + FIRST_BIT + WIDTH - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_cnt_inc;
    logic [5:0]       slot_off;
    logic [WIDTH-1:0] left_hold;
    logic [WIDTH-1:0] shift_reg;
    logic             div_wrap;
    logic             rise_tick;
    logic             fall_tick;
    logic             in_window;
    logic             commit;

    // Offset the slot position by the format delay so one unsigned compare finds the data window.
    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        rise_tick   = div_wrap & ~bclk;
        fall_tick   = div_wrap & bclk;
        bit_cnt_inc = bit_cnt + 6'd1;
        slot_off    = {1'b0, bit_cnt[4:0]} - FIRST_SLOT;
        in_window   = (slot_off < SLOT_BITS);
        commit      = rise_tick & (bit_cnt == COMMIT_CNT);
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            div_cnt      <= '0;
            bclk         <= 1'b0;
            bit_cnt      <= 6'd0;
            adclrc       <= 1'b0;
            left_hold    <= '0;
            shift_reg    <= '0;
            left_out     <= '0;
            right_out    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall_tick) begin
                bit_cnt <= bit_cnt_inc;
                adclrc  <= bit_cnt_inc[5];
            end

            if (rise_tick && in_window) begin
                if (bit_cnt[5])
                    shift_reg <= WIDTH'({shift_reg, adcdat});
                else
                    left_hold <= WIDTH'({left_hold, adcdat});
            end

            // A commit always wins over an accept; it only flags overrun if the old pair was never taken.
            if (commit) begin
                left_out     <= left_hold;
                right_out    <= WIDTH'({shift_reg, adcdat});
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready)
                    overrun <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: codec model drives adcdat on bclk falls, checks clocks, capture and handshake.
// Expected values follow the I2S_RX_LJ_EN build setting when it is defined.
module tb_i2s_adc_rx;

`ifdef I2S_RX_LJ_EN
    localparam bit LJ_BUILD    = 1'b1;
    localparam int COMMIT_EDGE = 760;
`else
    localparam bit LJ_BUILD    = 1'b0;
    localparam int COMMIT_EDGE = 776;
`endif

    logic        osc_clk = 1'b0;
    logic        reset = 1'b0;
    logic        adcdat;
    logic        sample_ready = 1'b0;
    logic        bclk;
    logic        adclrc;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        sample_valid;
    logic        overrun;

    logic [15:0] left_word = 16'h0000;
    logic [15:0] right_word = 16'h0000;
    bit          lj_stream = LJ_BUILD;
    logic [5:0]  pos = 6'd0;

    int vectors = 0;
    int miscompares = 0;

    i2s_adc_rx #(.WIDTH(16), .BCLK_DIV(8)) dut (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .bclk         (bclk),
        .adclrc       (adclrc),
        .adcdat       (adcdat),
        .left_out     (left_out),
        .right_out    (right_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 osc_clk = ~osc_clk;

    function automatic logic bit_for(input logic [5:0] p);
        int          slot;
        int          first;
        logic [15:0] w;
        slot  = int'(p[4:0]);
        first = lj_stream ? 0 : 1;
        w     = p[5] ? right_word : left_word;
        if (slot >= first && slot < first + 16)
            return w[15 - (slot - first)];
        return 1'b0;
    endfunction

    // Codec side: frame position follows bclk falls, restarting whenever reset is applied.
    always @(negedge bclk or posedge reset) begin
        if (reset)
            pos = 6'd0;
        else
            pos = pos + 6'd1;
        adcdat = bit_for(pos);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input bit lj);
        left_word  = l;
        right_word = r;
        lj_stream  = lj;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge osc_clk);
        #1;
        reset = 1'b0;
    endtask

    // Counts osc_clk edges until the chosen output reaches level; 0=bclk 1=adclrc 2=sample_valid 3=overrun.
    task automatic wait_sig(input int which, input logic level, input int limit, output int n);
        logic v;
        n = 0;
        do begin
            @(posedge osc_clk);
            #1;
            n++;
            case (which)
                0:       v = bclk;
                1:       v = adclrc;
                2:       v = sample_valid;
                default: v = overrun;
            endcase
        end while (v !== level && n < limit);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int n;

        @(posedge osc_clk);
        #1;
        applyStimulus(16'h0000, 16'h0000, LJ_BUILD);
        do_reset(5);
        checkOutput("rst_bclk", 32'(bclk), 32'd0);
        checkOutput("rst_adclrc", 32'(adclrc), 32'd0);
        checkOutput("rst_left", 32'(left_out), 32'd0);
        checkOutput("rst_right", 32'(right_out), 32'd0);
        checkOutput("rst_valid", 32'(sample_valid), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);

        wait_sig(0, 1'b1, 100, n);
        checkOutput("bclk_first_rise", 32'(n), 32'd8);
        wait_sig(0, 1'b0, 100, n);
        checkOutput("bclk_high_half", 32'(n), 32'd8);
        wait_sig(0, 1'b1, 100, n);
        checkOutput("bclk_low_half", 32'(n), 32'd8);
        wait_sig(1, 1'b1, 2000, n);
        checkOutput("adclrc_first_rise", 32'(n), 32'd488);
        wait_sig(1, 1'b0, 2000, n);
        checkOutput("adclrc_high", 32'(n), 32'd512);
        wait_sig(1, 1'b1, 2000, n);
        checkOutput("adclrc_low", 32'(n), 32'd512);

        // Normal capture with the consumer always ready.
        sample_ready = 1'b1;
        applyStimulus(16'hA5C3, 16'h5A3C, LJ_BUILD);
        do_reset(5);
        wait_sig(2, 1'b1, 3000, n);
        checkOutput("cap_latency", 32'(n), 32'(COMMIT_EDGE));
        checkOutput("cap_left", 32'(left_out), 32'h0000A5C3);
        checkOutput("cap_right", 32'(right_out), 32'h00005A3C);
        @(posedge osc_clk);
        #1;
        checkOutput("cap_valid_drop", 32'(sample_valid), 32'd0);
        checkOutput("cap_overrun", 32'(overrun), 32'd0);
        checkOutput("cap_hold_left", 32'(left_out), 32'h0000A5C3);

        // Two frames with nobody reading: the second overwrites and flags overrun.
        sample_ready = 1'b0;
        applyStimulus(16'h1234, 16'h5678, LJ_BUILD);
        do_reset(5);
        wait_sig(2, 1'b1, 3000, n);
        checkOutput("ovr_f1_latency", 32'(n), 32'(COMMIT_EDGE));
        checkOutput("ovr_f1_left", 32'(left_out), 32'h00001234);
        checkOutput("ovr_f1_right", 32'(right_out), 32'h00005678);
        applyStimulus(16'h9ABC, 16'hDEF0, LJ_BUILD);
        wait_sig(3, 1'b1, 3000, n);
        checkOutput("ovr_f2_delay", 32'(n), 32'd1024);
        checkOutput("ovr_f2_left", 32'(left_out), 32'h00009ABC);
        checkOutput("ovr_f2_right", 32'(right_out), 32'h0000DEF0);
        checkOutput("ovr_f2_valid", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        @(posedge osc_clk);
        #1;
        checkOutput("ovr_accept_valid", 32'(sample_valid), 32'd0);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);
        repeat (3) @(posedge osc_clk);
        #1;
        checkOutput("ovr_sticky_later", 32'(overrun), 32'd1);

        // Accept lands in the very cycle of the next commit.
        sample_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, LJ_BUILD);
        do_reset(5);
        wait_sig(2, 1'b1, 3000, n);
        checkOutput("same_f1_latency", 32'(n), 32'(COMMIT_EDGE));
        applyStimulus(16'h3333, 16'h4444, LJ_BUILD);
        repeat (1023) @(posedge osc_clk);
        #1;
        sample_ready = 1'b1;
        @(posedge osc_clk);
        #1;
        sample_ready = 1'b0;
        checkOutput("same_left", 32'(left_out), 32'h00003333);
        checkOutput("same_right", 32'(right_out), 32'h00004444);
        checkOutput("same_valid", 32'(sample_valid), 32'd1);
        checkOutput("same_overrun", 32'(overrun), 32'd0);

        // Reset in the middle of the left slot, then a clean frame.
        applyStimulus(16'h8001, 16'h7FFE, LJ_BUILD);
        n = 0;
        while (pos != 6'd20 && n < 3000) begin
            @(posedge osc_clk);
            #1;
            n++;
        end
        checkOutput("mid_reach_bit20", 32'(pos), 32'd20);
        do_reset(1);
        checkOutput("mid_rst_left", 32'(left_out), 32'd0);
        checkOutput("mid_rst_right", 32'(right_out), 32'd0);
        checkOutput("mid_rst_valid", 32'(sample_valid), 32'd0);
        checkOutput("mid_rst_bclk", 32'(bclk), 32'd0);
        checkOutput("mid_rst_adclrc", 32'(adclrc), 32'd0);
        wait_sig(2, 1'b1, 3000, n);
        checkOutput("mid_latency", 32'(n), 32'(COMMIT_EDGE));
        checkOutput("mid_left", 32'(left_out), 32'h00008001);
        checkOutput("mid_right", 32'(right_out), 32'h00007FFE);

        // Left-justified stream: exact in the LJ build, shifted by one bit in the I2S build.
        sample_ready = 1'b1;
        applyStimulus(16'h8001, 16'hFFFF, 1'b1);
        do_reset(5);
        wait_sig(2, 1'b1, 3000, n);
        checkOutput("fmt_latency", 32'(n), 32'(COMMIT_EDGE));
        if (LJ_BUILD) begin
            checkOutput("fmt_left", 32'(left_out), 32'h00008001);
            checkOutput("fmt_right", 32'(right_out), 32'h0000FFFF);
        end else begin
            checkOutput("fmt_left", 32'(left_out), 32'h00000002);
            checkOutput("fmt_right", 32'(right_out), 32'h0000FFFE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- I2S master-mode receiver for the codec ADC path; the capture-side counterpart of the DACDAT transmitter.
- Generates bit clock (bclk) and ADC word clock (adclrc) from osc_clk.
- Deserialises adcdat into left/right samples and hands each stereo pair to the fabric over a valid/ready interface with sticky overrun detection.

Parameters:
- WIDTH, 16: sample bits per channel; legal range 1..31 (1..32 with I2S_RX_LJ_EN).
- BCLK_DIV, 8: osc_clk cycles per bclk half-period; minimum 2.

Ports:
- osc_clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bclk  output  1  I2S bit clock to codec, registered.
- adclrc  output  1  word clock; 0 = left slot, 1 = right slot; registered.
- adcdat  input  1  serial ADC data from codec, MSB first.
- left_out  output  WIDTH  last committed left sample.
- right_out  output  WIDTH  last committed right sample.
- sample_valid  output  1  stereo pair available.
- sample_ready  input  1  consumer accepts the pair.
- overrun  output  1  sticky: a pair was overwritten before it was accepted.

Behaviour:
- Reset values: bclk=0, adclrc=0, div_cnt=0, bit_cnt=0, shift register=0, left_out=0, right_out=0, sample_valid=0, overrun=0. Reset mid-frame abandons the frame; generation restarts from slot bit 0.
- Divider: div_cnt counts 0..BCLK_DIV-1. bclk toggles in the cycle div_cnt wraps. bclk period = 2*BCLK_DIV cycles; first rise BCLK_DIV cycles after reset release.
- Frame: 64 bclk periods, 32 per channel slot. bit_cnt (6 bits, 0..63) advances on each bclk falling edge and wraps 63->0. adclrc = bit_cnt[5], so it changes on bclk falling edges.
- Capture: adcdat is sampled in the osc_clk cycle in which bclk is driven 0->1 (rise_tick).
  - I2S format: one-bit delay; slot bits 1..WIDTH hold MSB..LSB.
  - All other slot bits are ignored.
  - Left bits go to a left holding register; right bits shift directly.
- Commit occurs on the rise_tick capturing the right LSB (bit_cnt = 32+WIDTH). In the next osc_clk cycle:
  - left_out and right_out update together; they never change at any other time.
  - sample_valid = 1.
- Handshake:
  - sample_valid stays 1 until a cycle with sample_valid & sample_ready; it is 0 the following cycle.
  - Outputs hold while valid.
- Overrun: a commit while sample_valid=1 and sample_ready=0 overwrites the outputs, keeps valid=1 and sets overrun=1. overrun clears only on reset.
- Commit and accept in the same cycle: old pair consumed, new pair loaded, valid stays 1, no overrun.
- Latency: right LSB capture to sample_valid = 1 cycle. Pair rate = osc_clk/(128*BCLK_DIV) (97.656 kHz at 100 MHz, default).

Optional Feature:
- Macro I2S_RX_LJ_EN.
- Defined: left-justified format, no delay. MSB at slot bit 0, LSB at slot bit WIDTH-1. Commit at bit_cnt = 31+WIDTH. WIDTH may be 32.
- Undefined: standard I2S one-bit delay as above.

Test Plan:
- Reset for 5 cycles, release -> all outputs 0; bclk first rises at cycle 8; bclk period 16 cycles; adclrc period 1024 cycles, high for 512.
- Codec model drives adcdat on bclk falling edges with left=16'hA5C3, right=16'h5A3C, sample_ready=1 -> left_out=A5C3, right_out=5A3C; sample_valid one cycle after the right LSB rise_tick; valid drops the following cycle; overrun=0.
- sample_ready=0 across two frames (frame1 1234/5678, frame2 9ABC/DEF0) -> after second commit outputs=9ABC/DEF0, sample_valid=1, overrun=1; overrun persists after ready=1.
- sample_ready pulsed high exactly in the commit cycle of frame2 while frame1 pending -> frame2 loaded, valid=1, overrun=0.
- Reset asserted at left slot bit 20 -> outputs and counters zero next cycle; next full frame 0x8001/0x7FFE captured correctly.
- Build with I2S_RX_LJ_EN, send 0x8001/0xFFFF with no delay bit -> captured exactly; the same stream without the macro yields 0x0002/0xFFFE-shifted values, confirming the format difference.
